// File: rtl/inv_matvec_apply.sv
// inv_matvec_apply: applies a 2x2 Q2.14 inverse matrix to a Q2.14 vector.
// Two-stage valid/ready pipeline: products in stage 1; sum, round,
// saturate and error masking in stage 2. Status counters track output
// handshakes.
module inv_matvec_apply #(
  parameter int W     = 16,
  parameter int FRAC  = 14,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] a_inv,
  input  logic signed [W-1:0] b_inv,
  input  logic signed [W-1:0] c_inv,
  input  logic signed [W-1:0] d_inv,
  input  logic                inv_err,
  input  logic signed [W-1:0] y0,
  input  logic signed [W-1:0] y1,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] x0,
  output logic signed [W-1:0] x1,
  output logic                out_err,
  output logic [1:0]          out_sat,
  output logic [CNT_W-1:0]    vec_count,
  output logic [CNT_W-1:0]    err_count
);

  localparam int PW = 2 * W;
  localparam int SW = 2 * W + 1;

  localparam logic signed [SW-1:0] RND   = SW'(64'sd1 <<< (FRAC - 1));
  localparam logic signed [SW-1:0] X_MAX = SW'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] X_MIN = -X_MAX - SW'(1);

  // Round half toward +inf, drop FRAC bits, clamp to W bits.
  // Returns {sat, value}.
  function automatic logic [W:0] round_sat(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] r;
    logic [W:0]           res;
    r = (s + RND) >>> FRAC;
    if (r > X_MAX) begin
      res = {1'b1, X_MAX[W-1:0]};
    end else if (r < X_MIN) begin
      res = {1'b1, X_MIN[W-1:0]};
    end else begin
      res = {1'b0, r[W-1:0]};
    end
    return res;
  endfunction

  logic                 s2_adv;
  logic                 accept;
  logic                 xfer;

  logic                 vld_p1;
  logic                 err_p1;
  logic signed [PW-1:0] p00_p1;
  logic signed [PW-1:0] p01_p1;
  logic signed [PW-1:0] p10_p1;
  logic signed [PW-1:0] p11_p1;

  logic signed [PW-1:0] p00_c;
  logic signed [PW-1:0] p01_c;
  logic signed [PW-1:0] p10_c;
  logic signed [PW-1:0] p11_c;
  logic signed [SW-1:0] s0_c;
  logic signed [SW-1:0] s1_c;
  logic [W:0]           r0_c;
  logic [W:0]           r1_c;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !vld_p1 || s2_adv;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  // Full-precision Q4.28 products of the incoming beat.
  always_comb begin
    p00_c = PW'(a_inv) * PW'(y0);
    p01_c = PW'(b_inv) * PW'(y1);
    p10_c = PW'(c_inv) * PW'(y0);
    p11_c = PW'(d_inv) * PW'(y1);
  end

  // ---- stage 1: product registers ----

  // Stage-1 valid: loads on accept, drains when the stage advances empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= accept;
    end
  end

  // Stage-1 data; errored beats carry zero products so nothing stale leaks.
  always_ff @(posedge clk) begin
    if (accept) begin
      err_p1 <= inv_err;
      p00_p1 <= inv_err ? '0 : p00_c;
      p01_p1 <= inv_err ? '0 : p01_c;
      p10_p1 <= inv_err ? '0 : p10_c;
      p11_p1 <= inv_err ? '0 : p11_c;
    end
  end

  // Sum pairs in Q5.28 and reduce to Q2.14.
  always_comb begin
    s0_c = SW'(p00_p1) + SW'(p01_p1);
    s1_c = SW'(p10_p1) + SW'(p11_p1);
    r0_c = round_sat(s0_c);
    r1_c = round_sat(s1_c);
  end

  // ---- stage 2: output registers ----

  // Output register: loads when stage 2 advances, holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      x0        <= '0;
      x1        <= '0;
      out_err   <= 1'b0;
      out_sat   <= 2'b00;
    end else if (s2_adv) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_err <= err_p1;
        if (err_p1) begin
          x0      <= '0;
          x1      <= '0;
          out_sat <= 2'b00;
        end else begin
          x0      <= r0_c[W-1:0];
          x1      <= r1_c[W-1:0];
          out_sat <= {r1_c[W], r0_c[W]};
        end
      end
    end
  end

  // Status counters advance only on an output handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      vec_count <= '0;
      err_count <= '0;
    end else if (xfer) begin
      vec_count <= vec_count + CNT_W'(1);
      if (out_err && (err_count != {CNT_W{1'b1}})) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule
